// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA-style raster timing generator.
// Produces a pixel tick from the system clock, the raster counters,
// delayed sync/display-enable aligned to the pixel fetch latency,
// line/frame/vblank strobes and a completed-frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 32,
  parameter int SYNC_NEG   = 1,
  parameter int PIPE_DELAY = 2,
  parameter int CNT_W      = 11,
  parameter int FRAME_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               pix_en,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic               fetch_active,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VB_PREV  = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             SYNC_POL = (SYNC_NEG != 0);

  // Pipeline stage layout: bit 2 = active, bit 1 = hsync, bit 0 = vsync (all active-high raw)
  logic [DIV_W-1:0]                div_q, div_d;
  logic                            pix_en_q, pix_en_d;
  logic [CNT_W-1:0]                h_count_q, h_count_d;
  logic [CNT_W-1:0]                v_count_q, v_count_d;
  logic [FRAME_W-1:0]              frame_count_q, frame_count_d;
  logic                            line_start_q, line_start_d;
  logic                            frame_start_q, frame_start_d;
  logic                            vblank_start_q, vblank_start_d;
  logic [PIPE_DELAY-1:0][2:0]      pipe_q, pipe_d;

  logic raw_act, raw_hs, raw_vs;
  logic h_wrap, v_wrap;

  // Raw raster decode from the undelayed counters
  always_comb begin
    raw_act = (h_count_q < H_ACT) && (v_count_q < V_ACT);
    raw_hs  = (h_count_q >= HS_START) && (h_count_q < HS_END);
    raw_vs  = (v_count_q >= VS_START) && (v_count_q < VS_END);
    h_wrap  = (h_count_q == H_LAST);
    v_wrap  = (v_count_q == V_LAST);
  end

  // Clock divider producing a single-cycle pixel tick each time it wraps
  always_comb begin
    div_d    = '0;
    pix_en_d = 1'b0;
    if (enable) begin
      if (div_q == DIV_LAST) begin
        div_d    = '0;
        pix_en_d = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Raster counters, frame counter and strobes, advancing on pixel ticks
  always_comb begin
    h_count_d      = h_count_q;
    v_count_d      = v_count_q;
    frame_count_d  = frame_count_q;
    line_start_d   = 1'b0;
    frame_start_d  = 1'b0;
    vblank_start_d = 1'b0;
    if (!enable) begin
      h_count_d = '0;
      v_count_d = '0;
    end else if (pix_en_q) begin
      if (h_wrap) begin
        h_count_d    = '0;
        line_start_d = 1'b1;
        if (v_wrap) begin
          v_count_d     = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + FRAME_W'(1);
        end else begin
          v_count_d = v_count_q + CNT_W'(1);
          if (v_count_q == VB_PREV) begin
            vblank_start_d = 1'b1;
          end
        end
      end else begin
        h_count_d = h_count_q + CNT_W'(1);
      end
    end
  end

  // Alignment pipeline carrying raw active/sync bits forward one stage per tick
  always_comb begin
    pipe_d = pipe_q;
    if (!enable) begin
      pipe_d = '0;
    end else if (pix_en_q) begin
      pipe_d[0] = {raw_act, raw_hs, raw_vs};
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  // State registers with asynchronous reset to the idle, inactive raster
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q          <= '0;
      pix_en_q       <= 1'b0;
      h_count_q      <= '0;
      v_count_q      <= '0;
      frame_count_q  <= '0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      pipe_q         <= '0;
    end else begin
      div_q          <= div_d;
      pix_en_q       <= pix_en_d;
      h_count_q      <= h_count_d;
      v_count_q      <= v_count_d;
      frame_count_q  <= frame_count_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      pipe_q         <= pipe_d;
    end
  end

  assign pix_en       = pix_en_q;
  assign h_count      = h_count_q;
  assign v_count      = v_count_q;
  assign fetch_active = raw_act;
  assign de           = pipe_q[PIPE_DELAY-1][2];
  assign h_sync       = pipe_q[PIPE_DELAY-1][1] ^ SYNC_POL;
  assign v_sync       = pipe_q[PIPE_DELAY-1][0] ^ SYNC_POL;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// Three instances share clock/reset/enable:
//   dut_s : tiny raster (H 8/2/2/2, V 4/1/1/1), CLK_DIV=1, PIPE_DELAY=1, FRAME_W=2
//   dut_b : same raster, CLK_DIV=2, PIPE_DELAY=3, active-high syncs
//   dut_d : default 640x480 timing
// Expected values come from closed-form raster arithmetic on the number
// of clock edges k since the run started (edge 1 = first edge with enable high).
module tb_vga_timing_gen;

  logic clk;
  logic reset;
  logic enable;

  logic        s_pix_en, s_fa, s_hs, s_vs, s_de, s_ls, s_fs, s_vb;
  logic [10:0] s_h, s_v;
  logic [1:0]  s_fc;

  logic        b_pix_en, b_fa, b_hs, b_vs, b_de, b_ls, b_fs, b_vb;
  logic [10:0] b_h, b_v;
  logic [15:0] b_fc;

  logic        d_pix_en, d_fa, d_hs, d_vs, d_de, d_ls, d_fs, d_vb;
  logic [10:0] d_h, d_v;
  logic [15:0] d_fc;

  int checks;
  int errors;
  int cur_k;
  int ls_cnt, vb_cnt, fs_cnt;

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_NEG(1), .PIPE_DELAY(1), .CNT_W(11), .FRAME_W(2)
  ) dut_s (
    .clk(clk), .reset(reset), .enable(enable),
    .pix_en(s_pix_en), .h_count(s_h), .v_count(s_v), .fetch_active(s_fa),
    .h_sync(s_hs), .v_sync(s_vs), .de(s_de),
    .line_start(s_ls), .frame_start(s_fs), .vblank_start(s_vb),
    .frame_count(s_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_NEG(0), .PIPE_DELAY(3), .CNT_W(11), .FRAME_W(16)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .pix_en(b_pix_en), .h_count(b_h), .v_count(b_v), .fetch_active(b_fa),
    .h_sync(b_hs), .v_sync(b_vs), .de(b_de),
    .line_start(b_ls), .frame_start(b_fs), .vblank_start(b_vb),
    .frame_count(b_fc)
  );

  vga_timing_gen dut_d (
    .clk(clk), .reset(reset), .enable(enable),
    .pix_en(d_pix_en), .h_count(d_h), .v_count(d_v), .fetch_active(d_fa),
    .h_sync(d_hs), .v_sync(d_vs), .de(d_de),
    .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vb),
    .frame_count(d_fc)
  );

  // 10 ns system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic rst, input logic en);
    reset  = rst;
    enable = en;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s k=%0d observed=%0d expected=%0d", tag, cur_k, observed, expected);
    end
  endtask

  // All three instances idle: counters zero, no ticks, inactive pipeline, no strobes
  task automatic checkIdle(input int fc_s, input int fc_b, input int fc_d);
    checkOutput("s.idle.pix_en", 32'(s_pix_en), 0);
    checkOutput("s.idle.h", 32'(s_h), 0);
    checkOutput("s.idle.v", 32'(s_v), 0);
    checkOutput("s.idle.de", 32'(s_de), 0);
    checkOutput("s.idle.hsync", 32'(s_hs), 1);
    checkOutput("s.idle.vsync", 32'(s_vs), 1);
    checkOutput("s.idle.strobes", 32'({s_ls, s_fs, s_vb}), 0);
    checkOutput("s.idle.fc", 32'(s_fc), 32'(fc_s));
    checkOutput("b.idle.pix_en", 32'(b_pix_en), 0);
    checkOutput("b.idle.h", 32'(b_h), 0);
    checkOutput("b.idle.v", 32'(b_v), 0);
    checkOutput("b.idle.de", 32'(b_de), 0);
    checkOutput("b.idle.hsync", 32'(b_hs), 0);
    checkOutput("b.idle.vsync", 32'(b_vs), 0);
    checkOutput("b.idle.strobes", 32'({b_ls, b_fs, b_vb}), 0);
    checkOutput("b.idle.fc", 32'(b_fc), 32'(fc_b));
    checkOutput("d.idle.pix_en", 32'(d_pix_en), 0);
    checkOutput("d.idle.h", 32'(d_h), 0);
    checkOutput("d.idle.v", 32'(d_v), 0);
    checkOutput("d.idle.de", 32'(d_de), 0);
    checkOutput("d.idle.hsync", 32'(d_hs), 1);
    checkOutput("d.idle.vsync", 32'(d_vs), 1);
    checkOutput("d.idle.strobes", 32'({d_ls, d_fs, d_vb}), 0);
    checkOutput("d.idle.fc", 32'(d_fc), 32'(fc_d));
  endtask

  // Running raster after edge k of a run, with frame counters starting at base_s/base_b
  task automatic checkAll(input int k, input int base_s, input int base_b);
    int t, h, v, p, hp, vp;
    bit just;
    cur_k = k;

    // dut_s: one tick per edge, one stage of delay, active-low syncs
    t = k - 1;
    h = t % 14;
    v = (t / 14) % 7;
    checkOutput("s.pix_en", 32'(s_pix_en), 1);
    checkOutput("s.h", 32'(s_h), 32'(h));
    checkOutput("s.v", 32'(s_v), 32'(v));
    checkOutput("s.fetch", 32'(s_fa), 32'(h < 8 && v < 4));
    if (t >= 1) begin
      p = t - 1; hp = p % 14; vp = (p / 14) % 7;
      checkOutput("s.de", 32'(s_de), 32'(hp < 8 && vp < 4));
      checkOutput("s.hsync", 32'(s_hs), 32'(!(hp == 10 || hp == 11)));
      checkOutput("s.vsync", 32'(s_vs), 32'(vp != 5));
    end else begin
      checkOutput("s.de", 32'(s_de), 0);
      checkOutput("s.hsync", 32'(s_hs), 1);
      checkOutput("s.vsync", 32'(s_vs), 1);
    end
    checkOutput("s.line_start", 32'(s_ls), 32'(t > 0 && h == 0));
    checkOutput("s.frame_start", 32'(s_fs), 32'(t > 0 && h == 0 && v == 0));
    checkOutput("s.vblank_start", 32'(s_vb), 32'(t > 0 && h == 0 && v == 4));
    checkOutput("s.fc", 32'(s_fc), 32'((base_s + t / 98) % 4));

    // dut_b: tick every other edge, three stages of delay, active-high syncs
    t = (k - 1) / 2;
    h = t % 14;
    v = (t / 14) % 7;
    just = (k % 2 == 1) && (k >= 3);
    checkOutput("b.pix_en", 32'(b_pix_en), 32'(k % 2 == 0));
    checkOutput("b.h", 32'(b_h), 32'(h));
    checkOutput("b.v", 32'(b_v), 32'(v));
    if (t >= 3) begin
      p = t - 3; hp = p % 14; vp = (p / 14) % 7;
      checkOutput("b.de", 32'(b_de), 32'(hp < 8 && vp < 4));
      checkOutput("b.hsync", 32'(b_hs), 32'(hp == 10 || hp == 11));
      checkOutput("b.vsync", 32'(b_vs), 32'(vp == 5));
    end else begin
      checkOutput("b.de", 32'(b_de), 0);
      checkOutput("b.hsync", 32'(b_hs), 0);
      checkOutput("b.vsync", 32'(b_vs), 0);
    end
    checkOutput("b.line_start", 32'(b_ls), 32'(just && h == 0));
    checkOutput("b.frame_start", 32'(b_fs), 32'(just && h == 0 && v == 0));
    checkOutput("b.vblank_start", 32'(b_vb), 32'(just && h == 0 && v == 4));
    checkOutput("b.fc", 32'(b_fc), 32'(base_b + t / 98));

    // dut_d: default 800x525 raster, tick every fourth edge, two stages of delay
    t = (k - 1) / 4;
    h = t % 800;
    v = t / 800;
    just = (k % 4 == 1) && (k >= 5);
    checkOutput("d.pix_en", 32'(d_pix_en), 32'(k % 4 == 0));
    checkOutput("d.h", 32'(d_h), 32'(h));
    checkOutput("d.v", 32'(d_v), 32'(v));
    checkOutput("d.fetch", 32'(d_fa), 32'(h < 640 && v < 480));
    if (t >= 2) begin
      p = t - 2; hp = p % 800; vp = p / 800;
      checkOutput("d.de", 32'(d_de), 32'(hp < 640 && vp < 480));
      checkOutput("d.hsync", 32'(d_hs), 32'(!(hp >= 656 && hp < 752)));
      checkOutput("d.vsync", 32'(d_vs), 32'(!(vp >= 490 && vp < 492)));
    end else begin
      checkOutput("d.de", 32'(d_de), 0);
      checkOutput("d.hsync", 32'(d_hs), 1);
      checkOutput("d.vsync", 32'(d_vs), 1);
    end
    checkOutput("d.line_start", 32'(d_ls), 32'(just && h == 0));
    checkOutput("d.frame_start", 32'(d_fs), 0);
    checkOutput("d.vblank_start", 32'(d_vb), 0);
    checkOutput("d.fc", 32'(d_fc), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cur_k  = 0;
    ls_cnt = 0;
    vb_cnt = 0;
    fs_cnt = 0;

    $display("[TB] reset values");
    applyStimulus(1'b1, 1'b0);
    tick(2);
    checkIdle(0, 0, 0);

    $display("[TB] reset released with enable low stays idle");
    applyStimulus(1'b0, 1'b0);
    tick(3);
    checkIdle(0, 0, 0);

    $display("[TB] free run past the first default-timing line wrap");
    applyStimulus(1'b0, 1'b1);
    for (int k = 1; k <= 3268; k++) begin
      tick(1);
      checkAll(k, 0, 0);
      if (k >= 2 && k <= 99) begin
        ls_cnt += int'(s_ls);
        vb_cnt += int'(s_vb);
        fs_cnt += int'(s_fs);
      end
    end
    cur_k = 0;
    checkOutput("s.line_starts_per_frame", 32'(ls_cnt), 7);
    checkOutput("s.vblank_starts_per_frame", 32'(vb_cnt), 1);
    checkOutput("s.frame_starts_per_frame", 32'(fs_cnt), 1);
    checkOutput("s.drop_point_h", 32'(s_h), 5);
    checkOutput("s.drop_point_v", 32'(s_v), 2);

    $display("[TB] enable dropped at h=5 v=2");
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkIdle(1, 16, 0);
    end

    $display("[TB] restart after enable");
    applyStimulus(1'b0, 1'b1);
    for (int k = 1; k <= 120; k++) begin
      tick(1);
      checkAll(k, 1, 16);
    end

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(1'b1, 1'b1);
    #1;
    cur_k = 0;
    checkIdle(0, 0, 0);
    tick(2);
    checkIdle(0, 0, 0);

    $display("[TB] restart after reset");
    applyStimulus(1'b0, 1'b1);
    for (int k = 1; k <= 120; k++) begin
      tick(1);
      checkAll(k, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync generator.
- Generates pixel-clock enable, horizontal/vertical counters, sync pulses and display-enable from the system clock. All timings, the clock divide ratio and the sync polarity are set by parameters.
- Adds a sync/DE alignment pipeline to match pixel-fetch latency, line/frame/vblank strobes, a frame counter and a run enable.
- Sits between the system clock domain and the framebuffer-read/pixel-output path.

Parameters:
CLK_DIV, 4, clk cycles per pixel (1..16); 1 means pix_en is high every enabled cycle
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 32, vertical back porch (lines)
SYNC_NEG, 1, 1 = syncs active-low, 0 = active-high
PIPE_DELAY, 2, pixel ticks of delay applied to h_sync/v_sync/de (1..8)
CNT_W, 11, width of h_count/v_count
FRAME_W, 16, width of frame_count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run enable; low synchronously clears the timing state
pix_en  out  1  one-clk pixel tick strobe
h_count  out  CNT_W  current pixel column, undelayed
v_count  out  CNT_W  current line, undelayed
fetch_active  out  1  h_count<H_ACTIVE && v_count<V_ACTIVE, undelayed (drives framebuffer address)
h_sync  out  1  delayed horizontal sync, polarity per SYNC_NEG
v_sync  out  1  delayed vertical sync, polarity per SYNC_NEG
de  out  1  delayed display enable, aligned with h_sync/v_sync
line_start  out  1  one-clk pulse: h_count just became 0
frame_start  out  1  one-clk pulse: h_count and v_count just became 0
vblank_start  out  1  one-clk pulse: v_count just became V_ACTIVE with h_count 0
frame_count  out  FRAME_W  completed-frame counter, wraps modulo 2^FRAME_W

Behaviour:
- Reset is asynchronous: reset (active-high) clears all state immediately; clk is the only clock.
- Reset values:
  - div counter 0; pix_en 0; h_count 0; v_count 0; frame_count 0.
  - line_start, frame_start, vblank_start all 0.
  - Pipeline filled with the inactive state, so de=0 and h_sync=v_sync=SYNC_NEG.
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = the same sum of the V_ parameters. Both must fit in CNT_W bits.
- Divider:
  - Counts 0..CLK_DIV-1 while enable=1.
  - pix_en is registered and is high for exactly one clk each time the divider wraps, so there are CLK_DIV clk cycles between ticks.
  - First pix_en occurs CLK_DIV clk cycles after enable rises, or after reset deasserts with enable high.
- Counters, advancing only on clk edges where pix_en=1:
  - h_count runs 0..H_TOTAL-1, then wraps to 0. This is an exclusive terminal count; there is no H_TOTAL state.
  - On an h wrap, v_count increments, running 0..V_TOTAL-1, then wraps to 0.
  - On a v wrap, frame_count increments.
- Raw decode, combinational from the undelayed counters:
  - act = fetch_active.
  - hs = H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC.
- Pipeline:
  - {act,hs,vs} shift through PIPE_DELAY registers, advancing only on pix_en clk edges.
  - de/h_sync/v_sync are driven from the last stage, with h_sync = hs XOR SYNC_NEG and v_sync = vs XOR SYNC_NEG.
  - Result: de reflects the counter state from PIPE_DELAY pixel ticks earlier.
- Strobes:
  - Registered; each is asserted in the clk cycle right after the pix_en edge that produced the qualifying counter value, and lasts one clk.
  - frame_start implies line_start in the same cycle.
  - No strobes are issued for the reset/initial (0,0) state; the first frame_start follows the first complete frame.
- enable=0:
  - Synchronously clears the divider, h_count, v_count, pix_en and all strobes.
  - Refills the pipeline with the inactive state.
  - frame_count holds its value.
  - Restart behaves exactly like the post-reset start.
- Reset asserted mid-line or mid-frame: all outputs go to their reset values immediately (asynchronously), with no partial strobes.

Test Plan:
1. Default params, reset then enable=1 -> pix_en period is 4 clk; h_count wraps 799->0; v_count wraps 524->0; 420000 pixel ticks per frame; frame_count=1 at the first frame_start.
2. Small params (H 8/2/2/2, V 4/1/1/1, CLK_DIV=1, PIPE_DELAY=1):
   - Line is 14 ticks and frame is 98.
   - Raw hs is high at h=10,11; h_sync is low during the ticks after h=10,11.
   - de is high for the 8 ticks following h=0..7 on lines 0..3.
3. PIPE_DELAY=3 versus PIPE_DELAY=1 on the same stimulus -> de/h_sync/v_sync edges are shifted by exactly 2 pixel ticks (2*CLK_DIV clk); counters and strobes are unchanged.
4. SYNC_NEG=0 -> h_sync/v_sync are the bitwise inverse of the SYNC_NEG=1 run; reset value is 0.
5. Strobes with small params:
   - line_start occurs 7 times per frame.
   - vblank_start occurs once, at v=4,h=0.
   - frame_start coincides with line_start.
   - FRAME_W=2: frame_count sequence is 1,2,3,0.
6. enable dropped at h=5,v=2, and separately reset pulsed mid-frame -> counters go to 0, de=0, syncs go inactive, no strobe pulses; frame_count holds under enable=0 and clears under reset; the restart timing matches scenario 1.
